// File: rtl/snake_game_ctrl.sv
// Snake game logic for a 4x4 playfield: head/apple/score registers, move tick, LFSR apple placement.
// Optional `WRAP_AROUND_EN: the head wraps at the edges and OVER is never reached.
module snake_game_ctrl #(
    parameter int unsigned TICK_CYCLES = 50_000_000,
    parameter int unsigned WIN_SCORE   = 10,
    parameter logic [3:0]  LFSR_SEED   = 4'b1001
) (
    input  logic       clock,
    input  logic       restart,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] position,
    output logic [3:0] apple,
    output logic [3:0] score,
    output logic       playing,
    output logic       game_over,
    output logic       win
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [3:0] WIN_SCORE_L = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2,
        ST_WIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [3:0]       position_q, position_d;
    logic [3:0]       apple_q, apple_d;
    logic [3:0]       score_q, score_d;
    logic [3:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0] tick_q, tick_d;

    dir_t       eff_dir;
    logic [1:0] head_row, head_col;
    logic [1:0] nxt_row, nxt_col;
    logic [3:0] next_pos;
    logic [3:0] lfsr_nxt;
    logic [3:0] score_inc;
    logic [3:0] apple_cand;
    logic       wall_hit;
    logic       move_edge;

    // A fresh press wins over the held direction; priority up > down > left > right.
    always_comb begin
        eff_dir = dir_q;
        if (btn_up)
            eff_dir = DIR_UP;
        else if (btn_down)
            eff_dir = DIR_DOWN;
        else if (btn_left)
            eff_dir = DIR_LEFT;
        else if (btn_right)
            eff_dir = DIR_RIGHT;
    end

    assign head_row = position_q[3:2];
    assign head_col = position_q[1:0];

    // Two-bit row/col arithmetic wraps naturally, which is exactly the wrap-around behaviour.
    always_comb begin
        nxt_row = head_row;
        nxt_col = head_col;
        case (eff_dir)
            DIR_UP:    nxt_row = head_row - 2'd1;
            DIR_DOWN:  nxt_row = head_row + 2'd1;
            DIR_LEFT:  nxt_col = head_col - 2'd1;
            default:   nxt_col = head_col + 2'd1;
        endcase
    end

    assign next_pos = {nxt_row, nxt_col};

`ifdef WRAP_AROUND_EN
    assign wall_hit = 1'b0;
`else
    always_comb begin
        wall_hit = 1'b0;
        case (eff_dir)
            DIR_UP:    wall_hit = (head_row == 2'd0);
            DIR_DOWN:  wall_hit = (head_row == 2'd3);
            DIR_LEFT:  wall_hit = (head_col == 2'd0);
            default:   wall_hit = (head_col == 2'd3);
        endcase
    end
`endif

    assign lfsr_nxt   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    assign score_inc  = score_q + 4'd1;
    // Never drop the new apple under the head.
    assign apple_cand = (lfsr_nxt == next_pos) ? (lfsr_nxt + 4'd1) : lfsr_nxt;
    assign move_edge  = (tick_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        position_d = position_q;
        apple_d    = apple_q;
        score_d    = score_q;
        lfsr_d     = lfsr_q;
        tick_d     = tick_q;

        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (start)
                    state_d = ST_PLAY;
            end
            ST_PLAY: begin
                dir_d = eff_dir;
                if (move_edge) begin
                    tick_d = '0;
                    lfsr_d = lfsr_nxt;
                    if (wall_hit) begin
                        state_d = ST_OVER;
                    end else begin
                        position_d = next_pos;
                        if (next_pos == apple_q) begin
                            score_d = score_inc;
                            apple_d = apple_cand;
                            if (score_inc == WIN_SCORE_L)
                                state_d = ST_WIN;
                        end
                    end
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            default: begin
                // OVER and WIN freeze everything until restart.
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_RIGHT;
            position_q <= 4'b0101;
            apple_q    <= 4'b1010;
            score_q    <= 4'd0;
            lfsr_q     <= LFSR_SEED;
            tick_q     <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            position_q <= position_d;
            apple_q    <= apple_d;
            score_q    <= score_d;
            lfsr_q     <= lfsr_d;
            tick_q     <= tick_d;
        end
    end

    assign position  = position_q;
    assign apple     = apple_q;
    assign score     = score_q;
    assign playing   = (state_q == ST_PLAY);
    assign game_over = (state_q == ST_OVER);
    assign win       = (state_q == ST_WIN);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with TICK_CYCLES=4, WIN_SCORE=2, LFSR_SEED=4'b1001.
module tb_snake_game_ctrl;

    logic       clock = 1'b0;
    logic       restart = 1'b0;
    logic       start = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic [3:0] position;
    logic [3:0] apple;
    logic [3:0] score;
    logic       playing;
    logic       game_over;
    logic       win;

    int n_chk  = 0;
    int n_fail = 0;

    snake_game_ctrl #(
        .TICK_CYCLES(4),
        .WIN_SCORE  (2),
        .LFSR_SEED  (4'b1001)
    ) dut (
        .clock    (clock),
        .restart  (restart),
        .start    (start),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .position (position),
        .apple    (apple),
        .score    (score),
        .playing  (playing),
        .game_over(game_over),
        .win      (win)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic p, input logic g, input logic w);
        check({tag, ".playing"},   {3'b0, playing},   {3'b0, p});
        check({tag, ".game_over"}, {3'b0, game_over}, {3'b0, g});
        check({tag, ".win"},       {3'b0, win},       {3'b0, w});
    endtask

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        btn_up    = u;
        btn_down  = d;
        btn_left  = l;
        btn_right = r;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    logic [3:0] frz_pos, frz_apple, frz_score;

    initial begin
        // Reset values
        do_restart();
        check("rst.position", position, 4'b0101);
        check("rst.apple", apple, 4'b1010);
        check("rst.score", score, 4'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        // No start: nothing moves in IDLE
        step(6);
        check("idle.position", position, 4'b0101);
        check_flags("idle", 1'b0, 1'b0, 1'b0);

        // Default direction right, first move exactly 4 cycles after entry
        pulse_start();
        check_flags("play", 1'b1, 1'b0, 1'b0);
        step(3);
        check("right.pre_tick", position, 4'b0101);
        step(1);
        check("right.tick1", position, 4'b0110);
        step(4);
        check("right.tick2", position, 4'b0111);
        step(4);
`ifdef WRAP_AROUND_EN
        check("right.wrap", position, 4'b0100);
        check_flags("right.wrap", 1'b1, 1'b0, 1'b0);
`else
        check("right.wall_pos", position, 4'b0111);
        check_flags("right.wall", 1'b0, 1'b1, 1'b0);
        // start ignored in OVER
        pulse_start();
        step(5);
        check("over.hold_pos", position, 4'b0111);
        check_flags("over.hold", 1'b0, 1'b1, 1'b0);
`endif
        check("right.apple", apple, 4'b1010);
        check("right.score", score, 4'd0);

        // Up into the top wall
        do_restart();
        set_btn(1'b1, 1'b0, 1'b0, 1'b0);
        pulse_start();
        step(4);
        check("up.tick1", position, 4'b0001);
        step(4);
`ifdef WRAP_AROUND_EN
        check("up.wrap", position, 4'b1101);
        check_flags("up.wrap", 1'b1, 1'b0, 1'b0);
`else
        check("up.wall_pos", position, 4'b0001);
        check_flags("up.wall", 1'b0, 1'b1, 1'b0);
`endif
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);

        // Down, right onto the apple, then up onto the second apple -> WIN
        do_restart();
        set_btn(1'b0, 1'b1, 1'b0, 1'b0);
        pulse_start();
        step(4);
        check("eat.tick1", position, 4'b1001);
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        step(4);
        check("eat.tick2", position, 4'b1010);
        check("eat.apple1", apple, 4'b0110);
        check("eat.score1", score, 4'd1);
        check_flags("eat1", 1'b1, 1'b0, 1'b0);
        set_btn(1'b1, 1'b0, 1'b0, 1'b0);
        step(4);
        check("win.position", position, 4'b0110);
        check("win.apple", apple, 4'b1101);
        check("win.score", score, 4'd2);
        check_flags("win", 1'b0, 1'b0, 1'b1);

        // Frozen in WIN while inputs churn
        frz_pos   = 4'b0110;
        frz_apple = 4'b1101;
        frz_score = 4'd2;
        for (int i = 0; i < 20; i++) begin
            set_btn(1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
            start = 1'(i % 7 == 3);
            step(1);
        end
        start = 1'b0;
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        check("frz.position", position, frz_pos);
        check("frz.apple", apple, frz_apple);
        check("frz.score", score, frz_score);
        check_flags("frz", 1'b0, 1'b0, 1'b1);

        // Apple lands on the new head: lfsr after 4 moves is 1010, so apple bumps to 1011
        do_restart();
        set_btn(1'b1, 1'b0, 1'b0, 1'b0);
        pulse_start();
        step(4);
        check("bump.tick1", position, 4'b0001);
        set_btn(1'b0, 1'b1, 1'b0, 1'b0);
        step(8);
        check("bump.tick3", position, 4'b1001);
        check("bump.apple_pre", apple, 4'b1010);
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        step(4);
        check("bump.position", position, 4'b1010);
        check("bump.apple", apple, 4'b1011);
        check("bump.score", score, 4'd1);
        check_flags("bump", 1'b1, 1'b0, 1'b0);

        // Mid-PLAY restart dominates start and buttons
        step(2);
        restart = 1'b1;
        start   = 1'b1;
        set_btn(1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        restart = 1'b0;
        start   = 1'b0;
        check("mid.position", position, 4'b0101);
        check("mid.apple", apple, 4'b1010);
        check("mid.score", score, 4'd0);
        check_flags("mid", 1'b0, 1'b0, 1'b0);
        step(5);
        check("mid.idle_pos", position, 4'b0101);
        check_flags("mid.idle", 1'b0, 1'b0, 1'b0);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
